inst_fetch_mem: RTL
===================

Name: inst_fetch_mem

Overview:
Parametrised instruction memory for the CPU fetch stage. It has a fetch request/response path with configurable read latency and a program-load write port. The block reports out-of-range accesses as tagged exception pulses aligned to the response, and can optionally clear the array after reset. It sits between the PC/fetch unit and the decode stage, and the test loader drives the load port.

Parameters:
INSTR_ADDR_WIDTH, 16, width of fetch and load addresses
INSTR_DATA_BIT_WIDTH, 16, instruction word width
INSTR_MEM_SIZE, 64, number of words; legal addresses are 0..INSTR_MEM_SIZE-1
READ_LATENCY, 1, cycles from accepted fetch to rdata_valid; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset release; 0 = contents retained

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
fetch_req  in  1  fetch request
fetch_addr  in  INSTR_ADDR_WIDTH  word address to fetch
fetch_ready  out  1  fetch accepted this cycle when fetch_req && fetch_ready
rdata_valid  out  1  one-cycle pulse marking a response
rdata  out  INSTR_DATA_BIT_WIDTH  instruction word; holds its value between responses
exc  out  1  pulse coincident with rdata_valid when the fetch was out of range
exc_addr  out  INSTR_ADDR_WIDTH  address of the last faulting fetch; held until the next fault
load_en  in  1  write strobe for the program-load port
load_addr  in  INSTR_ADDR_WIDTH  write address
load_data  in  INSTR_DATA_BIT_WIDTH  write data
load_err  out  1  pulse one cycle after an out-of-range load; no write occurs
busy  out  1  high while in CLEAR

Behaviour:
- Reset (rst=1, asynchronous, active-high). All outputs go to 0. The response pipeline is flushed and in-flight requests are dropped. The FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise RUN. Array contents are not touched during reset.
- FSM states: CLEAR, RUN.
  - CLEAR: one word is zeroed per cycle, using a counter from 0 up to INSTR_MEM_SIZE-1. busy=1 and fetch_ready=0. load_en is ignored and raises no load_err. The FSM moves to RUN after the last word, so CLEAR lasts exactly INSTR_MEM_SIZE cycles after reset release.
  - RUN: busy=0. fetch_ready = !load_en (combinational).
- Load priority. In RUN with load_en=1, the write happens at the clock edge and no fetch is accepted that cycle. In-flight responses still drain on schedule.
- Fetch acceptance. An accepted fetch enters a READ_LATENCY-deep pipeline carrying valid, the out-of-range flag and the address.
  - rdata_valid is asserted exactly READ_LATENCY cycles after the acceptance edge.
  - Back-to-back accepts give back-to-back responses, in order, at one per cycle.
- Read data. rdata = mem[fetch_addr] as it stood at the acceptance edge.
  - A load to the same address in cycle N is visible to a fetch accepted in cycle N+1 or later.
- Out-of-range fetch (fetch_addr >= INSTR_MEM_SIZE). No array read takes place. At response time rdata=0, rdata_valid=1, exc=1, and exc_addr captures the faulting address. The pipeline is not stalled.
- Out-of-range load (load_addr >= INSTR_MEM_SIZE). No write takes place and load_err=1 for one cycle in the next cycle. fetch_ready is still 0 in the load_en cycle.
- Widths. Address compares are full INSTR_ADDR_WIDTH unsigned, with no truncation or wrap-around. Data is not width-converted.
- Reset asserted mid-CLEAR restarts CLEAR from address 0. Reset asserted with responses in flight means those responses are never delivered.

Test Plan:
- CLEAR_ON_RESET=1, size 64: preload mem[5]=16'hBEEF, pulse rst, then fetch addr 5 -> busy high for exactly 64 cycles, fetch_ready=0 throughout, response rdata=16'h0000.
- READ_LATENCY=3: load 16'h1234 at addr 10, then fetch 10 in the next cycle -> rdata_valid 3 cycles after accept, rdata=16'h1234, exc=0.
- Fetch addrs 0,1,2 back-to-back (mem=0xA0,0xA1,0xA2), READ_LATENCY=2 -> three consecutive valid pulses carrying 0xA0,0xA1,0xA2 in order.
- Fetch addr 64 (size 64), then fetch addr 1 -> first response rdata=0, exc=1, exc_addr=64; second response exc=0 with correct data; exc_addr stays 64.
- load_en and fetch_req both asserted in the same cycle -> fetch_ready=0, write occurs, fetch accepted the following cycle. Load to addr 100 -> load_err pulse, no array change.
- rst asserted with 2 fetches in flight -> no rdata_valid pulses afterward; all outputs 0 during reset.

Source files
------------

// File: rtl/inst_fetch_mem.sv
// ============================================================================
// Module   : inst_fetch_mem
// Summary  : Instruction memory with latency-configurable fetch path and load port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch_mem #(
  parameter int INSTR_ADDR_WIDTH     = 16,
  parameter int INSTR_DATA_BIT_WIDTH = 16,
  parameter int INSTR_MEM_SIZE       = 64,
  parameter int READ_LATENCY         = 1,
  parameter int CLEAR_ON_RESET       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_req,
  input  logic [INSTR_ADDR_WIDTH-1:0]     fetch_addr,
  output logic                            fetch_ready,
  output logic                            rdata_valid,
  output logic [INSTR_DATA_BIT_WIDTH-1:0] rdata,
  output logic                            exc,
  output logic [INSTR_ADDR_WIDTH-1:0]     exc_addr,
  input  logic                            load_en,
  input  logic [INSTR_ADDR_WIDTH-1:0]     load_addr,
  input  logic [INSTR_DATA_BIT_WIDTH-1:0] load_data,
  output logic                            load_err,
  output logic                            busy
);

  localparam int AW    = INSTR_ADDR_WIDTH;
  localparam int DW    = INSTR_DATA_BIT_WIDTH;
  localparam int LAT   = READ_LATENCY;
  localparam int IDX_W = (INSTR_MEM_SIZE > 1) ? $clog2(INSTR_MEM_SIZE) : 1;
  localparam logic [AW:0]      SIZE_EXT = (AW+1)'(INSTR_MEM_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_MEM_SIZE - 1);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             load_err_q, load_err_d;

  // Per-stage response pipeline: valid, fault flag, data, last fault address.
  logic          pv_q     [LAT];
  logic          pv_d     [LAT];
  logic          poor_q   [LAT];
  logic          poor_d   [LAT];
  logic [DW-1:0] pdata_q  [LAT];
  logic [DW-1:0] pdata_d  [LAT];
  logic [AW-1:0] pfaddr_q [LAT];
  logic [AW-1:0] pfaddr_d [LAT];

  logic [DW-1:0] mem [INSTR_MEM_SIZE];

  logic             fetch_oor;
  logic             load_oor;
  logic             accept;
  logic [DW-1:0]    rd_word;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [DW-1:0]    mem_wdata;

  assign fetch_oor   = {1'b0, fetch_addr} >= SIZE_EXT;
  assign load_oor    = {1'b0, load_addr} >= SIZE_EXT;
  assign fetch_ready = (state_q == ST_RUN) && !load_en && !rst;
  assign busy        = (state_q == ST_CLEAR) && !rst;
  assign accept      = fetch_req && fetch_ready;
  assign rd_word     = mem[fetch_addr[IDX_W-1:0]];

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    load_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = load_addr[IDX_W-1:0];
    mem_wdata  = load_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (load_en) begin
          if (load_oor) load_err_d = 1'b1;
          else          mem_we     = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Later stages only take new data/fault address when a response moves in,
  // so the output stage holds the last delivered values.
  always_comb begin
    pv_d[0]     = accept;
    poor_d[0]   = accept && fetch_oor;
    pdata_d[0]  = accept ? (fetch_oor ? '0 : rd_word) : pdata_q[0];
    pfaddr_d[0] = (accept && fetch_oor) ? fetch_addr : pfaddr_q[0];
    for (int k = 1; k < LAT; k++) begin
      pv_d[k]     = pv_q[k-1];
      poor_d[k]   = poor_q[k-1];
      pdata_d[k]  = pv_q[k-1] ? pdata_q[k-1] : pdata_q[k];
      pfaddr_d[k] = (pv_q[k-1] && poor_q[k-1]) ? pfaddr_q[k-1] : pfaddr_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      clr_cnt_q  <= '0;
      load_err_q <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        pv_q[k]     <= 1'b0;
        poor_q[k]   <= 1'b0;
        pdata_q[k]  <= '0;
        pfaddr_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      load_err_q <= load_err_d;
      for (int k = 0; k < LAT; k++) begin
        pv_q[k]     <= pv_d[k];
        poor_q[k]   <= poor_d[k];
        pdata_q[k]  <= pdata_d[k];
        pfaddr_q[k] <= pfaddr_d[k];
      end
    end
  end

  // Array is never written while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_widx] <= mem_wdata;
  end

  assign rdata_valid = pv_q[LAT-1];
  assign exc         = pv_q[LAT-1] && poor_q[LAT-1];
  assign rdata       = pdata_q[LAT-1];
  assign exc_addr    = pfaddr_q[LAT-1];
  assign load_err    = load_err_q;

endmodule

`default_nettype wire
